// File: rtl/axi_mem_responder.sv
// axi_mem_responder: single-transaction AXI4 INCR responder backed by a 64-bit word memory.
// Define AXI_MEM_RESP_ERR_INJ_EN to honour err_inject_i (writes suppressed, SLVERR, read data zeroed).
module axi_mem_responder #(
    parameter int          IdWidth  = 4,
    parameter int          Depth    = 1024,
    parameter logic [63:0] BaseAddr = 64'h8000_0000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               aw_valid_i,
    output logic               aw_ready_o,
    input  logic [IdWidth-1:0] aw_id_i,
    input  logic [63:0]        aw_addr_i,
    input  logic [7:0]         aw_len_i,
    input  logic               w_valid_i,
    output logic               w_ready_o,
    input  logic [63:0]        w_data_i,
    input  logic [7:0]         w_strb_i,
    input  logic               w_last_i,
    output logic               b_valid_o,
    input  logic               b_ready_i,
    output logic [IdWidth-1:0] b_id_o,
    output logic [1:0]         b_resp_o,
    input  logic               ar_valid_i,
    output logic               ar_ready_o,
    input  logic [IdWidth-1:0] ar_id_i,
    input  logic [63:0]        ar_addr_i,
    input  logic [7:0]         ar_len_i,
    output logic               r_valid_o,
    input  logic               r_ready_i,
    output logic [IdWidth-1:0] r_id_o,
    output logic [63:0]        r_data_o,
    output logic [1:0]         r_resp_o,
    output logic               r_last_o,
    input  logic               err_inject_i
);
    localparam int AW = $clog2(Depth);
    localparam logic [63:0] DepthW = 64'(Depth);

    typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_e;
    state_e state_q, state_d;
    logic [63:0] idx_q, idx_d;
    logic [7:0] len_q, len_d, beat_q, beat_d;
    logic [IdWidth-1:0] id_q, id_d;
    logic base_ok_q, base_ok_d, dec_q, dec_d, mis_q, mis_d, inj_q, inj_d, prio_rd_q, prio_rd_d;
    logic [63:0] r_data_q;
    logic [1:0] r_resp_q, r_resp_d;
    logic r_last_q, r_last_d;
    logic [63:0] mem_q [Depth];
    logic idle, aw_hs, ar_hs, w_hs, r_hs, in_rng, nxt_rng, r_load, inj_in;
    logic [63:0] hs_addr;

`ifdef AXI_MEM_RESP_ERR_INJ_EN
    assign inj_in = err_inject_i;
`else
    logic unused_inj;
    assign unused_inj = err_inject_i;
    assign inj_in = 1'b0;
`endif

    // With no request pending, the favoured channel advertises ready.
    assign idle       = (state_q == IDLE) && !rst_i;
    assign ar_ready_o = idle && (ar_valid_i ? (!aw_valid_i || prio_rd_q) : (!aw_valid_i && prio_rd_q));
    assign aw_ready_o = idle && !ar_ready_o && (aw_valid_i || !prio_rd_q);
    assign w_ready_o  = (state_q == WDATA) && !rst_i;
    assign b_valid_o  = (state_q == WRESP) && !rst_i;
    assign r_valid_o  = (state_q == RDATA) && !rst_i;
    assign aw_hs      = aw_valid_i && aw_ready_o;
    assign ar_hs      = ar_valid_i && ar_ready_o;
    assign w_hs       = w_valid_i && w_ready_o;
    assign r_hs       = r_valid_o && r_ready_i;
    assign hs_addr    = ar_hs ? ar_addr_i : aw_addr_i;
    assign in_rng     = base_ok_q && (idx_q < DepthW);
    assign r_load     = ar_hs || (r_hs && !r_last_q);
    assign b_id_o     = id_q;
    assign r_id_o     = id_q;
    assign r_data_o   = r_data_q;
    assign r_resp_o   = r_resp_q;
    assign r_last_o   = r_last_q;
    assign b_resp_o   = dec_q ? 2'b11 : (mis_q || inj_q) ? 2'b10 : 2'b00;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        beat_d    = beat_q;
        id_d      = id_q;
        base_ok_d = base_ok_q;
        dec_d     = dec_q;
        mis_d     = mis_q;
        inj_d     = inj_q;
        prio_rd_d = prio_rd_q;
        r_resp_d  = r_resp_q;
        r_last_d  = r_last_q;
        case (state_q)
            IDLE: if (aw_hs || ar_hs) begin
                state_d   = ar_hs ? RDATA : WDATA;
                idx_d     = (hs_addr - BaseAddr) >> 3;
                base_ok_d = hs_addr >= BaseAddr;
                len_d     = ar_hs ? ar_len_i : aw_len_i;
                id_d      = ar_hs ? ar_id_i : aw_id_i;
                beat_d    = '0;
                dec_d     = 1'b0;
                mis_d     = 1'b0;
                inj_d     = inj_in;
                prio_rd_d = !ar_hs;
                r_last_d  = ar_hs && (ar_len_i == 8'd0);
            end
            WDATA: if (w_hs) begin
                idx_d   = idx_q + 64'd1;
                beat_d  = beat_q + 8'd1;
                dec_d   = dec_q || !in_rng;
                mis_d   = mis_q || (w_last_i != (beat_q == len_q));
                state_d = w_last_i ? WRESP : WDATA;
            end
            WRESP: state_d = b_ready_i ? IDLE : WRESP;
            RDATA: if (r_hs) begin
                state_d  = r_last_q ? IDLE : RDATA;
                idx_d    = idx_q + 64'd1;
                beat_d   = beat_q + 8'd1;
                r_last_d = (beat_q + 8'd1) == len_q;
            end
            default: state_d = IDLE;
        endcase
        // Read data is prefetched for the beat that will be presented next.
        nxt_rng = base_ok_d && (idx_d < DepthW);
        if (r_load) r_resp_d = !nxt_rng ? 2'b11 : inj_d ? 2'b10 : 2'b00;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            id_q      <= '0;
            base_ok_q <= 1'b0;
            dec_q     <= 1'b0;
            mis_q     <= 1'b0;
            inj_q     <= 1'b0;
            prio_rd_q <= 1'b1;
            r_data_q  <= '0;
            r_resp_q  <= '0;
            r_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            id_q      <= id_d;
            base_ok_q <= base_ok_d;
            dec_q     <= dec_d;
            mis_q     <= mis_d;
            inj_q     <= inj_d;
            prio_rd_q <= prio_rd_d;
            r_resp_q  <= r_resp_d;
            r_last_q  <= r_last_d;
            if (r_load) r_data_q <= (nxt_rng && !inj_d) ? mem_q[idx_d[AW-1:0]] : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_hs && in_rng && !inj_q)
            for (int b = 0; b < 8; b++)
                if (w_strb_i[b]) mem_q[idx_q[AW-1:0]][8*b +: 8] <= w_data_i[8*b +: 8];
    end
endmodule
